// File: rtl/rv32i_pkg.sv
// rv32i: shared RV32I types and helpers.
//   mem_op_e     - RAM/core memory operation encoding
//   funct3 consts - load/store width selectors
//   lsu_state_e  - load/store unit FSM states
//   load_extract - lane select plus sign/zero extension of a loaded word
//   store_merge  - insert store data into the addressed lane(s) of a word
package rv32i;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  // Loads
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  // Stores
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE      = 2'd0,
    LSU_LOAD_RESP = 2'd1,
    LSU_MERGE     = 2'd2,
    LSU_ACK       = 2'd3
  } lsu_state_e;

  // Pick the byte/halfword lane at off and extend it to XLEN bits.
  function automatic logic [XLEN-1:0] load_extract(
    input logic [XLEN-1:0] word,
    input logic [1:0]      off,
    input logic [2:0]      funct3
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      res = {{24{b[7]}}, b};
      LH:      res = {{16{h[15]}}, h};
      LBU:     res = {24'd0, b};
      LHU:     res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overwrite the addressed lane(s) of word with the low bits of wdata.
  function automatic logic [XLEN-1:0] store_merge(
    input logic [XLEN-1:0] word,
    input logic [XLEN-1:0] wdata,
    input logic [1:0]      off,
    input logic [2:0]      funct3
  );
    logic [XLEN-1:0] res;
    res = word;
    case (funct3)
      SB: res[{off, 3'b000} +: 8] = wdata[7:0];
      SH: begin
        if (off[1]) res[31:16] = wdata[15:0];
        else        res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu.sv
// lsu: load/store unit between the core memory stage and the word-addressed
// data RAM. Loads are extended, SW writes directly, SB/SH use a
// read-modify-write, and illegal/misaligned requests are answered with
// resp_err without touching the RAM.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_op/req_funct3            operation and width
//   req_addr/req_wdata           byte address, right-aligned store data
//   resp_valid/resp_rdata/resp_err  one-cycle completion
//   ram_addr/ram_wdata/ram_mem_op   RAM request (RAM registers the address)
//   ram_rdata                    RAM read data, valid one cycle after ram_addr
module lsu
  import rv32i::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  mem_op_e         req_op,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] ram_addr,
  output logic [XLEN-1:0] ram_wdata,
  output mem_op_e         ram_mem_op,
  input  logic [XLEN-1:0] ram_rdata
);

  localparam int unsigned WADDR_W = XLEN - 2;

  lsu_state_e         r_state;
  lsu_state_e         w_next_state;
  logic [1:0]         r_off;
  logic [2:0]         r_funct3;
  logic [XLEN-1:0]    r_wdata;
  logic [WADDR_W-1:0] r_word_addr;
  logic               r_err;

  logic w_accept;
  logic w_is_load;
  logic w_is_store;
  logic w_bad_f3;
  logic w_misalign;
  logic w_err;

  assign w_is_load  = (req_op == MEM_LOAD);
  assign w_is_store = (req_op == MEM_STORE);

  // funct3 011/110/111 have no meaning for either loads or stores.
  assign w_bad_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);

  // Halfword needs addr[0]==0, word needs addr[1:0]==00.
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  assign w_err = !(w_is_load || w_is_store) || w_bad_f3 ||
                 (w_is_store && req_funct3[2]) || w_misalign;

  assign req_ready = (r_state == LSU_IDLE) && reset_n;
  assign w_accept  = req_valid && req_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= LSU_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request capture on acceptance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_off       <= 2'd0;
      r_funct3    <= 3'd0;
      r_wdata     <= '0;
      r_word_addr <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_off       <= req_addr[1:0];
      r_funct3    <= req_funct3;
      r_wdata     <= req_wdata;
      r_word_addr <= req_addr[XLEN-1:2];
      r_err       <= w_err;
    end
  end

  // Next state, RAM port and response
  always_comb begin
    w_next_state = r_state;
    ram_addr     = {r_word_addr, 2'b00};
    ram_wdata    = '0;
    ram_mem_op   = MEM_NONE;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_err     = 1'b0;

    case (r_state)
      LSU_IDLE: begin
        // RAM address follows the request so the read/write starts this cycle.
        ram_addr = {req_addr[XLEN-1:2], 2'b00};
        if (w_accept) begin
          if (w_err) begin
            w_next_state = LSU_ACK;
          end else if (w_is_load) begin
            ram_mem_op   = MEM_LOAD;
            w_next_state = LSU_LOAD_RESP;
          end else if (req_funct3 == SW) begin
            ram_mem_op   = MEM_STORE;
            ram_wdata    = req_wdata;
            w_next_state = LSU_ACK;
          end else begin
            // Sub-word store: fetch the word first, merge next cycle.
            ram_mem_op   = MEM_LOAD;
            w_next_state = LSU_MERGE;
          end
        end
      end

      LSU_LOAD_RESP: begin
        resp_valid   = 1'b1;
        resp_rdata   = load_extract(ram_rdata, r_off, r_funct3);
        w_next_state = LSU_IDLE;
      end

      LSU_MERGE: begin
        ram_mem_op   = MEM_STORE;
        ram_wdata    = store_merge(ram_rdata, r_wdata, r_off, r_funct3);
        w_next_state = LSU_ACK;
      end

      LSU_ACK: begin
        resp_valid   = 1'b1;
        resp_err     = r_err;
        w_next_state = LSU_IDLE;
      end

      default: w_next_state = LSU_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomized checks of lsu against a byte-array memory
// model, with a word RAM model attached to the RAM port.
module tb_lsu;
  import rv32i::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  mem_op_e     req_op = MEM_NONE;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  mem_op_e     ram_mem_op;
  logic [31:0] ram_rdata;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_mem_op (ram_mem_op),
    .ram_rdata  (ram_rdata)
  );

  // Word RAM with registered address; preload port used only during reset.
  logic [31:0] ram [0:1023];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = 10'd0;
  logic [31:0] pre_data = 32'd0;

  always @(posedge clk) begin
    if (pre_en) ram[pre_idx] <= pre_data;
    else if (ram_mem_op == MEM_STORE) ram[ram_addr[11:2]] <= ram_wdata;
    ram_rdata <= ram[ram_addr[11:2]];
  end

  // Reference memory: one entry per byte of the 4 KB space.
  logic [7:0] mem_b [0:4095];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_err(input mem_op_e op, input logic [2:0] f3, input logic [31:0] a);
    if (op != MEM_LOAD && op != MEM_STORE) return 1'b1;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (op == MEM_STORE && f3 >= 3'd4) return 1'b1;
    if ((int'(a[1:0]) % acc_size(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Little-endian assemble, then sign-extend when the load is signed.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int    n;
    int    base;
    longint v;
    n = acc_size(f3);
    base = int'(a[11:0]);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(mem_b[base + i]) << (8 * i);
    if (f3[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n;
    int base;
    n = acc_size(f3);
    base = int'(a[11:0]);
    for (int i = 0; i < n; i++) mem_b[base + i] = wd[8 * i +: 8];
  endtask

  // One request: check RAM port at acceptance, latency, store count, response.
  task automatic do_req(input string tag, input mem_op_e op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    logic        e;
    logic [31:0] exp_rd;
    mem_op_e     exp_op;
    int          exp_lat;
    int          exp_nst;
    int          lat;
    int          nst;
    logic        er;
    e       = model_err(op, f3, a);
    exp_rd  = (!e && op == MEM_LOAD) ? model_load(f3, a) : 32'd0;
    exp_op  = e ? MEM_NONE : ((op == MEM_STORE && f3 == 3'b010) ? MEM_STORE : MEM_LOAD);
    exp_lat = (!e && op == MEM_STORE && f3 != 3'b010) ? 2 : 1;
    exp_nst = (!e && op == MEM_STORE) ? 1 : 0;
    rd = 32'd0;
    er = 1'b0;
    lat = 0;
    nst = 0;

    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1;
    check32({tag, " ready"}, 32'(req_ready), 32'd1);
    check32({tag, " accept op"}, 32'(ram_mem_op), 32'(exp_op));
    check32({tag, " ram_addr"}, ram_addr, {a[31:2], 2'b00});
    if (exp_op == MEM_STORE) check32({tag, " sw wdata"}, ram_wdata, wd);
    if (ram_mem_op == MEM_STORE) nst++;

    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (ram_mem_op == MEM_STORE) nst++;
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    check32({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check32({tag, " stores"}, 32'(nst), 32'(exp_nst));
    check32({tag, " rdata"}, rd, exp_rd);
    check32({tag, " err"}, 32'(er), 32'(e));
    @(posedge clk); #1;
    check32({tag, " pulse end"}, 32'(resp_valid), 32'd0);
    check32({tag, " idle"}, 32'(req_ready), 32'd1);
    if (!e && op == MEM_STORE) model_store(f3, a, wd);
  endtask

  // Hold req_valid high for n cycles; accepts must be gap cycles apart.
  task automatic stream(input string tag, input mem_op_e op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int gap, input int n);
    int          acc;
    int          rsp;
    int          last;
    logic [31:0] exp_rd;
    acc = 0; rsp = 0; last = -1;
    exp_rd = (op == MEM_LOAD) ? model_load(f3, a) : 32'd0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int c = 0; c < n; c++) begin
      if (req_ready) begin
        if (last >= 0) check32({tag, " gap"}, 32'(c - last), 32'(gap));
        last = c;
        acc++;
      end
      if (resp_valid) begin
        rsp++;
        check32({tag, " rdata"}, resp_rdata, exp_rd);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) rsp++;
      @(negedge clk);
    end
    check32({tag, " accepts"}, 32'(acc), 32'((n + gap - 1) / gap));
    check32({tag, " resps"}, 32'(rsp), 32'(acc));
    if (op == MEM_STORE) model_store(f3, a, wd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    mem_op_e     op;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;

    // Random initial contents for the exercised window 0x100..0x13F.
    for (int i = 0; i < 4096; i++) mem_b[i] = 8'h00;
    for (int i = 32'h100; i < 32'h140; i++) mem_b[i] = 8'($urandom);
    for (int w = 0; w < 16; w++) begin
      @(negedge clk);
      pre_en = 1'b1;
      pre_idx = 10'(64 + w);
      pre_data = {mem_b[256 + 4*w + 3], mem_b[256 + 4*w + 2], mem_b[256 + 4*w + 1], mem_b[256 + 4*w]};
    end
    @(negedge clk);
    pre_en = 1'b0;
    req_valid = 1'b1;
    #1;
    check32("reset resp_valid", 32'(resp_valid), 32'd0);
    check32("reset resp_rdata", resp_rdata, 32'd0);
    check32("reset resp_err", 32'(resp_err), 32'd0);
    check32("reset ram_mem_op", 32'(ram_mem_op), 32'(MEM_NONE));
    check32("reset req_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Directed test plan
    do_req("SW 100", MEM_STORE, SW, 32'h100, 32'hDEADBEEF, rd);
    do_req("LW 100", MEM_LOAD, LW, 32'h100, 32'h0, rd);
    check32("LW 100 value", rd, 32'hDEADBEEF);
    do_req("SB 101", MEM_STORE, SB, 32'h101, 32'h123456AA, rd);
    do_req("LW 100b", MEM_LOAD, LW, 32'h100, 32'h0, rd);
    check32("LW after SB value", rd, 32'hDEADAAEF);
    do_req("LB 101", MEM_LOAD, LB, 32'h101, 32'h0, rd);
    check32("LB 101 value", rd, 32'hFFFFFFAA);
    do_req("LBU 101", MEM_LOAD, LBU, 32'h101, 32'h0, rd);
    check32("LBU 101 value", rd, 32'h000000AA);
    do_req("LH 102", MEM_LOAD, LH, 32'h102, 32'h0, rd);
    check32("LH 102 value", rd, 32'hFFFFDEAD);
    do_req("LHU 102", MEM_LOAD, LHU, 32'h102, 32'h0, rd);
    check32("LHU 102 value", rd, 32'h0000DEAD);
    do_req("SH 103 err", MEM_STORE, SH, 32'h103, 32'hFFFFFFFF, rd);
    do_req("LW 102 err", MEM_LOAD, LW, 32'h102, 32'h0, rd);
    do_req("f3 011 err", MEM_LOAD, 3'b011, 32'h100, 32'h0, rd);
    do_req("op bad err", mem_op_e'(2'b11), LW, 32'h100, 32'h0, rd);
    do_req("S f3 100 err", MEM_STORE, 3'b100, 32'h100, 32'h0, rd);
    do_req("LW after errs", MEM_LOAD, LW, 32'h100, 32'h0, rd);
    check32("LW after errs value", rd, 32'hDEADAAEF);

    // Reset during MERGE of SB 0x55 to 0x100
    @(negedge clk);
    req_valid = 1'b1; req_op = MEM_STORE; req_funct3 = SB; req_addr = 32'h100; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check32("merge reached", 32'(ram_mem_op), 32'(MEM_STORE));
    reset_n = 1'b0;
    #1;
    check32("rst merge op", 32'(ram_mem_op), 32'(MEM_NONE));
    check32("rst merge resp", 32'(resp_valid), 32'd0);
    check32("rst merge ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check32("rst hold resp", 32'(resp_valid), 32'd0);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check32("post rst resp", 32'(resp_valid), 32'd0);
    end
    do_req("LW after abort", MEM_LOAD, LW, 32'h100, 32'h0, rd);
    check32("LW after abort value", rd, 32'hDEADAAEF);

    // Randomized requests, including high address bits that alias
    for (int t = 0; t < 80; t++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0) op = ($urandom_range(0, 1) == 0) ? MEM_NONE : mem_op_e'(2'b11);
      else if (r < 9) op = MEM_LOAD;
      else op = MEM_STORE;
      f3 = (op == MEM_STORE && $urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 2))
                                                         : 3'($urandom_range(0, 7));
      a = {20'd0, 12'h100 + 12'($urandom_range(0, 63))};
      if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom);
      do_req("rand", op, f3, a, $urandom, rd);
    end

    // Back-to-back request pressure
    stream("LW stream", MEM_LOAD, LW, 32'h104, 32'h0, 2, 14);
    stream("LB stream", MEM_LOAD, LB, 32'h10B, 32'h0, 2, 9);
    stream("SB stream", MEM_STORE, SB, 32'h10A, 32'h0000003C, 3, 15);
    do_req("LW after SB stream", MEM_LOAD, LW, 32'h108, 32'h0, rd);
    do_req("LBU after SB stream", MEM_LOAD, LBU, 32'h10A, 32'h0, rd);
    check32("SB stream byte", rd, 32'h0000003C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
